// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan controller.
//   NUM_DIGITS / SEL_W : digit count and width of the digit select
//   ANODE_OFF          : active-low anode pattern with every digit dark
//   scan_state_t       : scan controller states
//   onehot_n()         : active-low one-hot anode pattern for a digit select
package seg7_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int SEL_W      = 2;
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } scan_state_t;

    function automatic logic [NUM_DIGITS-1:0] onehot_n(input logic [SEL_W-1:0] sel);
        logic [NUM_DIGITS-1:0] pat;
        pat      = ANODE_OFF;
        pat[sel] = 1'b0;
        return pat;
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_slot_counter.sv
// Modulo-DIV counter used as a prescaler.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to 0 (wins over en)
//   en         : count enable
//   cnt        : current count, 0..DIV-1
//   wrap       : combinational, high while en=1 and cnt=DIV-1 (the count
//                returns to 0 on the next edge)
module seg7_scan_ctrl_slot_counter #(
    parameter int DIV   = 8,
    parameter int CNT_W = $clog2(DIV)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);

    assign wrap = en && (cnt == CNT_W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexing scan controller for a 4-digit seven-segment display.
// Each digit slot lasts REFRESH_DIV cycles: BLANK_CYCLES dark cycles first
// (the digit mux and decoder settle), then the selected anode is driven.
//   CLK, RESET : clock, asynchronous active-low reset
//   EN         : scan enable; 0 parks the scan at digit 0 with the display dark
//   DIGIT_EN   : per-digit enable; bit i = 0 keeps anode i off in its slot
//   MUX_SEL    : digit select for the digit mux CONTROL input
//   ANODE_N    : active-low one-hot anode enables
//   TICK       : one-cycle pulse on every slot advance
//   FRAME      : one-cycle pulse when MUX_SEL wraps 3 -> 0
//   dbg_state  : current scan state, for observation only
//
// All outputs are registered. MUX_SEL and the next ANODE_N are computed from
// the same next-state decision, so an anode is never low while MUX_SEL
// points at another digit.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  EN,
    input  logic [NUM_DIGITS-1:0] DIGIT_EN,
    output logic [SEL_W-1:0]      MUX_SEL,
    output logic [NUM_DIGITS-1:0] ANODE_N,
    output logic                  TICK,
    output logic                  FRAME,
    output scan_state_t           dbg_state
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    // Last blank count; only meaningful when BLANK_CYCLES > 0.
    localparam int BLANK_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
    // State entered at the start of every slot.
    localparam scan_state_t SLOT_START = (BLANK_CYCLES == 0) ? DRIVE : BLANK;

    scan_state_t           state, next_state;
    logic [CNT_W-1:0]      cnt;
    logic                  wrap;
    logic                  adv;
    logic [SEL_W-1:0]      sel_next;
    logic [NUM_DIGITS-1:0] anode_next;

    // The counter only runs inside a slot; EN low clears it.
    seg7_scan_ctrl_slot_counter #(
        .DIV   (REFRESH_DIV),
        .CNT_W (CNT_W)
    ) u_slot_counter (
        .clk   (CLK),
        .rst_n (RESET),
        .clr   (!EN),
        .en    (EN && (state != IDLE)),
        .cnt   (cnt),
        .wrap  (wrap)
    );

    always_comb begin
        next_state = state;
        adv        = 1'b0;
        case (state)
            IDLE: begin
                if (EN) next_state = SLOT_START;
            end
            BLANK: begin
                if (wrap)                          adv        = 1'b1;
                else if (cnt == CNT_W'(BLANK_LAST)) next_state = DRIVE;
            end
            DRIVE: begin
                if (wrap) adv = 1'b1;
            end
            default: next_state = IDLE;
        endcase
        if (adv) next_state = SLOT_START;
        // Abort wins over a slot advance and issues no pulses.
        if (!EN) begin
            next_state = IDLE;
            adv        = 1'b0;
        end

        sel_next = MUX_SEL;
        if (!EN)     sel_next = '0;
        else if (adv) sel_next = MUX_SEL + SEL_W'(1);

        // With no dead time the new digit lights on the same edge MUX_SEL moves.
        anode_next = ANODE_OFF;
        if (next_state == DRIVE) anode_next = onehot_n(sel_next) | ~DIGIT_EN;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state   <= IDLE;
            MUX_SEL <= '0;
            ANODE_N <= ANODE_OFF;
            TICK    <= 1'b0;
            FRAME   <= 1'b0;
        end else begin
            state   <= next_state;
            MUX_SEL <= sel_next;
            ANODE_N <= anode_next;
            TICK    <= adv;
            FRAME   <= adv && (MUX_SEL == SEL_W'(NUM_DIGITS - 1));
        end
    end

    assign dbg_state = state;

endmodule
